dmem_param: RTL and testbench
=============================

# dmem_param

Parametrised, latency-programmable data memory model for the baseline processor's memory stage. It accepts one read or one write request at a time and holds it for a fixed number of cycles, then returns read data or write completion with a one-cycle done pulse. It adds several things a fixed 64×32 memory does not have: configurable width, depth and latency, a busy indication, out-of-range error reporting, and an optional byte-lane write mask. Control state is reset asynchronously.

## Interface
Parameters:
- DATA_W, 32: word width in bits; multiple of 8.
- DEPTH, 64: number of words.
- ADDR_W, 10: byte-address width.
- LATENCY, 4: cycles from request acceptance to done; legal range 1..255.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears control state and outputs.
- read  in  1  read request; sampled at posedge.
- write  in  1  write request; sampled at posedge.
- memAddr  in  ADDR_W  byte address; word index = memAddr >> log2(DATA_W/8).
- wData  in  DATA_W  write data.
- byteEn  in  DATA_W/8  byte-lane write mask; present only with DMEM_BYTEMASK_EN.
- rData  out  DATA_W  read data, registered.
- done_r  out  1  one-cycle read-complete pulse.
- done_w  out  1  one-cycle write-complete pulse.
- busy  out  1  request in flight.
- err  out  1  one-cycle pulse coincident with done; out-of-range access.

## Operation
- States: IDLE, BUSY. Reset value is IDLE.
- Reset values: rData=0, done_r=0, done_w=0, busy=0, err=0, counter=0.
- In IDLE, if write=1 at a posedge, a write is accepted. Otherwise, if read=1, a read is accepted. If both are high, the write has priority; the read is dropped and produces no done_r.
- On acceptance:
  - Latch the operation, word index, wData and byteEn.
  - Load the counter with LATENCY-1.
  - Go to BUSY.
- In BUSY, at each posedge:
  - If counter≠0: decrement the counter.
  - If counter=0: perform the operation, pulse the matching done, return to IDLE.
- read/write are ignored while in BUSY. There is no queuing; the requester must hold or re-issue the request.
- A write commits to the array at the completion edge, not at acceptance.
- A read samples the array at the completion edge. It therefore sees any write that completed earlier.
- Out of range (word index ≥ DEPTH):
  - No array access.
  - done pulses normally, with err=1 in the same cycle.
  - For a read, rData=0.
- rData holds the last completed read value until the next read completes. Writes do not change rData.
- busy = (state==BUSY).
- Array contents are not affected by reset. At time zero, word i is preloaded with value i, zero-extended to DATA_W.
- Reset asserted mid-operation:
  - The in-flight operation is abandoned.
  - A pending write is not committed.
  - No done or err pulse is produced.

## Timing
- Accept edge = E. done_r/done_w (and err, if applicable) rise at edge E+LATENCY and fall at E+LATENCY+1.
- rData is valid from edge E+LATENCY.
- busy is high from E to E+LATENCY, and low in the done cycle.
- The earliest next acceptance is edge E+LATENCY+1. Peak throughput is one operation per LATENCY+1 cycles.
- LATENCY=1: done rises at the edge immediately after acceptance.
- Outputs are all registered; there are no combinational input→output paths.

## Configuration
- DMEM_BYTEMASK_EN defined:
  - The byteEn port exists.
  - On write completion, lane k (bits 8k+7:8k) is updated only if byteEn[k]=1.
  - byteEn=0 still completes with a done_w pulse and leaves the word unchanged.
- DMEM_BYTEMASK_EN undefined:
  - There is no byteEn port.
  - Every write updates the full word.

## Test plan
- Preload check: after reset, read addr 0x0C with LATENCY=4. Required: busy for 4 cycles, done_r at E+4, rData=3, err=0.
- Write then read: write 0xDEADBEEF to addr 0x10, wait for done_w, then read 0x10. Required: rData=0xDEADBEEF, and a single-cycle pulse on each done.
- Busy rejection: issue a read, then issue a write to 0x04 two cycles later while busy. Required: the write is ignored (no done_w), and a later read of 0x04 returns 1.
- Simultaneous read+write to 0x08 with wData=0x55. Required: only done_w pulses, and a subsequent read returns 0x55.
- Out of range: read addr 0x100 with DEPTH=64. Required: done_r and err pulse together and rData=0; a write to 0x100 gives done_w+err, and every in-range word is unchanged.
- Reset mid-write: write 0xAA to 0x14, assert reset at E+2. Required: all outputs 0 immediately, no done, and a subsequent read of 0x14 returns 5. With DMEM_BYTEMASK_EN: write 0xFFFFFFFF with byteEn=4'b0101 to 0x00 → read returns 0x00FF00FF.

Source files
------------

// File: rtl/dmem_param.sv
// dmem_param: parametrised, latency-programmable data memory for the memory stage.
// Accepts one read or write at a time, holds it for LATENCY cycles, then
// completes with a one-cycle done pulse (plus err for out-of-range words).
//
// Optional feature: define DMEM_BYTEMASK_EN to add the byteEn port and
// byte-lane masked writes; otherwise every write updates the full word.
//
// Ports:
//   clock   - single clock, all state updates on posedge
//   reset   - asynchronous active-high; clears control state and outputs
//   read    - read request (sampled in IDLE)
//   write   - write request (sampled in IDLE, wins over read)
//   memAddr - byte address; word index = memAddr >> log2(DATA_W/8)
//   wData   - write data
//   byteEn  - byte-lane write mask (DMEM_BYTEMASK_EN only)
//   rData   - registered read data, holds last completed read
//   done_r  - one-cycle read-complete pulse
//   done_w  - one-cycle write-complete pulse
//   busy    - request in flight
//   err     - out-of-range access, coincident with done
module dmem_param #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   memAddr,
  input  logic [DATA_W-1:0]   wData,
`ifdef DMEM_BYTEMASK_EN
  input  logic [DATA_W/8-1:0] byteEn,
`endif
  output logic [DATA_W-1:0]   rData,
  output logic                done_r,
  output logic                done_w,
  output logic                busy,
  output logic                err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned BSH   = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IDX_W = ADDR_W - BSH;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Time-zero contents: word i holds i; reset never touches the array.
  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  mem_t mem_q = init_mem();

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]      ben_q, ben_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               done_r_q, done_r_d;
  logic               done_w_q, done_w_d;
  logic               err_q, err_d;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wval;
  logic [NB-1:0]      ben_in;
  logic               complete;
  logic               in_range;

`ifdef DMEM_BYTEMASK_EN
  assign ben_in = byteEn;
`else
  assign ben_in = '1;
`endif

  if (BSH > 0) begin : g_lo_unused
    logic unused_lo;
    assign unused_lo = ^memAddr[BSH-1:0];
  end

  assign complete = (state_q == BUSY) && (cnt_q == '0);
  assign in_range = (32'(idx_q) < DEPTH);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      ben_q    <= '0;
      rdata_q  <= '0;
      done_r_q <= 1'b0;
      done_w_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      ben_q    <= ben_d;
      rdata_q  <= rdata_d;
      done_r_q <= done_r_d;
      done_w_q <= done_w_d;
      err_q    <= err_d;
    end
  end

  // Array: commits only on a completing in-range write. mem_we derives from
  // state_q, so a reset-abandoned write never reaches the array.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx_q[AW-1:0]] <= mem_wval;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    unique case (state_q)
      IDLE: begin
        if (write || read) begin
          wr_d    = write;
          idx_d   = memAddr[ADDR_W-1:BSH];
          wdata_d = wData;
          ben_d   = ben_in;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 8'd1;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / completion logic (all results land in registers)
  always_comb begin
    done_r_d = 1'b0;
    done_w_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    mem_we   = 1'b0;
    mem_wval = mem_q[idx_q[AW-1:0]];
    for (int unsigned k = 0; k < NB; k++) begin
      if (ben_q[k]) mem_wval[8*k +: 8] = wdata_q[8*k +: 8];
    end
    if (complete) begin
      err_d = !in_range;
      if (wr_q) begin
        done_w_d = 1'b1;
        mem_we   = in_range;
      end else begin
        done_r_d = 1'b1;
        rdata_d  = in_range ? mem_q[idx_q[AW-1:0]] : '0;
      end
    end
  end

  assign rData  = rdata_q;
  assign done_r = done_r_q;
  assign done_w = done_w_q;
  assign err    = err_q;
  assign busy   = (state_q == BUSY);

endmodule

// File: tb/tb_dmem_param.sv
module tb_dmem_param;
  localparam int unsigned LAT = 4;
  localparam int unsigned DEP = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [9:0]  memAddr;
  logic [31:0] wData;
  logic [3:0]  byteEn;
  logic [31:0] rData;
  logic        done_r, done_w, busy, err;

  always #5 clock = ~clock;

  dmem_param #(
    .DATA_W(32),
    .DEPTH(DEP),
    .ADDR_W(10),
    .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .read(read),
    .write(write),
    .memAddr(memAddr),
    .wData(wData),
`ifdef DMEM_BYTEMASK_EN
    .byteEn(byteEn),
`endif
    .rData(rData),
    .done_r(done_r),
    .done_w(done_w),
    .busy(busy),
    .err(err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [DEP];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction, checked cycle by cycle against the timing rules.
  // intrude: drive a write to 0x04 while busy; it must be ignored.
  task automatic op(input bit w, input bit r, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] be, input bit intrude, input string tag);
    int unsigned idx;
    bit inr;
    logic [3:0] be_eff;
    logic [31:0] exp_rd;
    idx = 32'(a) >> 2;
    inr = (idx < DEP);
`ifdef DMEM_BYTEMASK_EN
    be_eff = be;
`else
    be_eff = 4'hF;
`endif
    if (w) begin
      if (inr) begin
        for (int k = 0; k < 4; k++)
          if (be_eff[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
    end else begin
      last_rd = inr ? model[idx] : 32'h0;
    end
    exp_rd = last_rd;

    @(negedge clock);
    write = w; read = r; memAddr = a; wData = d; byteEn = be;
    @(posedge clock); #1;
    check({tag, "_acc"}, {28'h0, busy, done_r, done_w, err}, 32'h8);
    for (int unsigned k = 1; k <= LAT; k++) begin
      @(negedge clock);
      read = 1'b0;
      write = intrude && (k >= 2) && (k <= LAT - 1);
      if (write) begin memAddr = 10'h004; wData = 32'h12345678; end
      @(posedge clock); #1;
      if (k < LAT)
        check({tag, "_wait"}, {28'h0, busy, done_r, done_w, err}, 32'h8);
      else begin
        check({tag, "_done"}, {28'h0, busy, done_r, done_w, err},
              {28'h0, 1'b0, !w, w, !inr});
        check({tag, "_rdata"}, rData, exp_rd);
      end
    end
    @(negedge clock);
    write = 1'b0;
    @(posedge clock); #1;
    check({tag, "_after"}, {28'h0, busy, done_r, done_w, err}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0;
    memAddr = '0; wData = '0; byteEn = '0;
    for (int i = 0; i < int'(DEP); i++) model[i] = 32'(i);
    last_rd = 32'h0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_out", {busy, done_r, done_w, err, rData[27:0]}, 32'h0);
    check("reset_rdata", rData, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    op(0, 1, 10'h00C, 32'h0, 4'hF, 0, "preload");
    check("preload_val", rData, 32'd3);
    op(1, 0, 10'h010, 32'hDEADBEEF, 4'hF, 0, "wr10");
    op(0, 1, 10'h010, 32'h0, 4'hF, 0, "rd10");
    check("rd10_val", rData, 32'hDEADBEEF);
    op(0, 1, 10'h00C, 32'h0, 4'hF, 1, "busyrej");
    op(0, 1, 10'h004, 32'h0, 4'hF, 0, "rd04");
    check("rd04_val", rData, 32'd1);
    op(1, 1, 10'h008, 32'h55, 4'hF, 0, "both");
    op(0, 1, 10'h008, 32'h0, 4'hF, 0, "rd08");
    check("rd08_val", rData, 32'h55);
    op(0, 1, 10'h100, 32'h0, 4'hF, 0, "oor_rd");
    check("oor_rd_val", rData, 32'h0);
    op(1, 0, 10'h100, 32'hCAFEF00D, 4'hF, 0, "oor_wr");

    // Reset in the middle of a write: abandoned, outputs cleared at once.
    @(negedge clock);
    write = 1'b1; memAddr = 10'h014; wData = 32'hAA; byteEn = 4'hF;
    @(posedge clock);
    @(negedge clock);
    write = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check("rst_mid_out", {28'h0, busy, done_r, done_w, err}, 32'h0);
    check("rst_mid_rdata", rData, 32'h0);
    last_rd = 32'h0;
    for (int unsigned k = 0; k < LAT; k++) begin
      @(posedge clock); #1;
      check("rst_hold", {28'h0, busy, done_r, done_w, err}, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    op(0, 1, 10'h014, 32'h0, 4'hF, 0, "rd14");
    check("rd14_val", rData, 32'd5);

`ifdef DMEM_BYTEMASK_EN
    op(1, 0, 10'h000, 32'hFFFFFFFF, 4'b0101, 0, "bmask_wr");
    op(0, 1, 10'h000, 32'h0, 4'hF, 0, "bmask_rd");
    check("bmask_val", rData, 32'h00FF00FF);
`endif

    for (int n = 0; n < 40; n++) begin
      bit w, r;
      logic [9:0] a;
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      a = ($urandom % 4 == 0) ? 10'($urandom_range(256, 1023)) : 10'($urandom_range(0, 255));
      op(w, r, a, $urandom, 4'($urandom), 0, "rand");
    end

    for (int unsigned i = 0; i < DEP; i++)
      op(0, 1, 10'(i * 4), 32'h0, 4'hF, 0, "scan");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
